// File: rtl/response_uart_tx_pkg.sv
// rtl/response_uart_tx_pkg.sv - shared FSM encodings and defaults for the response UART transmitter
package response_uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/response_uart_tx_if.sv
// rtl/response_uart_tx_if.sv - response byte handshake and UART line status bundle
interface response_uart_tx_if;
    logic       ready_to_read;
    logic [7:0] dataIn;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        output ready_to_read,
        output dataIn,
        input  tx,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  ready_to_read,
        input  dataIn,
        output tx,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/response_uart_tx_baud_counter.sv
// rtl/response_uart_tx_baud_counter.sv - per-bit cycle counter, pulses bit_tick on terminal count
module uart_baud_counter
    import response_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic computer_ack_reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_tick = enable && (count == TERMINAL);

    // Holds its value outside a frame; only clear or an enabled tick returns it to zero.
    always_ff @(posedge clock or posedge computer_ack_reset) begin
        if (computer_ack_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (bit_tick) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/response_uart_tx.sv
// rtl/response_uart_tx.sv - sends one captured response byte as an 8N1 UART frame per acknowledge
module response_uart_tx
    import response_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                clock,
    input  logic                computer_ack_reset,
    response_uart_tx_if.slave   bus
);
    tx_state_t  state;
    logic       rtr_q;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       tx_q;
    logic       busy_q;
    logic       tx_done_q;
    logic       start_cond;
    logic       baud_clear;
    logic       baud_enable;
    logic       bit_tick;

    assign start_cond  = bus.ready_to_read & ~rtr_q;
    assign baud_clear  = (state == ST_IDLE) && start_cond;
    assign baud_enable = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock              (clock),
        .computer_ack_reset (computer_ack_reset),
        .clear              (baud_clear),
        .enable             (baud_enable),
        .bit_tick           (bit_tick)
    );

    // rtr_q resets low, so a level already high at reset release starts a frame.
    always_ff @(posedge clock or posedge computer_ack_reset) begin
        if (computer_ack_reset) begin
            state     <= ST_IDLE;
            rtr_q     <= 1'b0;
            shift     <= 8'h00;
            bit_idx   <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            rtr_q <= bus.ready_to_read;
            case (state)
                ST_IDLE: begin
                    if (start_cond) begin
                        shift  <= bus.dataIn;
                        state  <= ST_START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state   <= ST_DATA;
                        bit_idx <= 3'd0;
                        tx_q    <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        // Next bit is driven from shift[1] since the shift lands this same edge.
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            tx_q  <= shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        state     <= ST_DONE;
                        tx_q      <= 1'b1;
                        busy_q    <= 1'b0;
                        tx_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    tx_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = tx_done_q;
endmodule

// File: tb/tb_response_uart_tx.sv
// tb/tb_response_uart_tx.sv - directed vector bench for response_uart_tx at 4 clocks per bit
module tb_response_uart_tx;
    localparam int CPB = 4;

    logic clock;
    logic computer_ack_reset;
    int   tests;
    int   failed;

    response_uart_tx_if bus ();

    response_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock              (clock),
        .computer_ack_reset (computer_ack_reset),
        .bus                (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       change_en;
        logic [7:0] change_val;
        logic [9:0] exp_frame;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.ready_to_read  = 1'b0;
        computer_ack_reset = 1'b1;
        @(negedge clock);
        computer_ack_reset = 1'b0;
    endtask

    // Raises ready_to_read at a negedge; the following posedge ends cycle E.
    task automatic run_frame(input vec_t v, input string tag);
        logic [7:0] decoded;
        int         low_cycles;
        decoded    = 8'h00;
        low_cycles = 0;
        bus.dataIn        = v.data;
        bus.ready_to_read = 1'b1;
        for (int c = 1; c <= 10 * CPB; c++) begin
            @(posedge clock);
            @(negedge clock);
            check({tag, " tx"}, 32'(bus.tx), 32'(v.exp_frame[(c - 1) / CPB]));
            if (bus.busy !== 1'b1) check({tag, " busy"}, 32'(bus.busy), 32'd1);
            if (bus.tx_done !== 1'b0) check({tag, " early_done"}, 32'(bus.tx_done), 32'd0);
            if (bus.tx === 1'b0 && c <= CPB) low_cycles++;
            if (((c - 1) % CPB) == 2 && ((c - 1) / CPB) >= 1 && ((c - 1) / CPB) <= 8)
                decoded[((c - 1) / CPB) - 1] = bus.tx;
            if (c == 10 && v.change_en) bus.dataIn = v.change_val;
        end
        check({tag, " start_len"}, 32'(low_cycles), 32'(CPB));
        check({tag, " decoded"}, 32'(decoded), 32'(v.exp_byte));
        @(posedge clock);
        @(negedge clock);
        check({tag, " done"}, 32'(bus.tx_done), 32'd1);
        check({tag, " busy_fall"}, 32'(bus.busy), 32'd0);
        check({tag, " idle_tx"}, 32'(bus.tx), 32'd1);
    endtask

    initial begin
        vec_t v01;
        tests  = 0;
        failed = 0;
        bus.ready_to_read  = 1'b0;
        bus.dataIn         = 8'h00;
        computer_ack_reset = 1'b1;

        vecs[0] = '{8'hA5, 1'b0, 8'h00, 10'b1101001010, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 8'hFF, 10'b1001111000, 8'h3C};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 10'b1000000000, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 8'h00, 10'b1111111110, 8'hFF};
        v01     = '{8'h01, 1'b0, 8'h00, 10'b1000000010, 8'h01};

        // Reset and idle
        repeat (3) @(negedge clock);
        check("rst tx", 32'(bus.tx), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.tx_done), 32'd0);
        computer_ack_reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0)
                check("idle", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b100);
        end
        check("idle end", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b100);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold in DONE: further edges ignored
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus.ready_to_read = 1'b0;
            @(negedge clock);
            bus.ready_to_read = 1'b1;
        end
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.tx_done !== 1'b1 || bus.busy !== 1'b0)
                check("hold", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b101);
        end
        check("hold end", 32'({bus.tx, bus.busy, bus.tx_done}), 32'b101);

        // Reset mid-frame at E+18, then a fresh frame
        do_reset();
        bus.dataIn        = 8'h5A;
        bus.ready_to_read = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("mid busy_pre", 32'(bus.busy), 32'd1);
        computer_ack_reset = 1'b1;
        bus.ready_to_read  = 1'b0;
        #1;
        check("mid tx", 32'(bus.tx), 32'd1);
        check("mid busy", 32'(bus.busy), 32'd0);
        check("mid done", 32'(bus.tx_done), 32'd0);
        @(negedge clock);
        computer_ack_reset = 1'b0;
        @(negedge clock);
        run_frame(v01, "after_mid");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
